selfcal_tx: RTL
===============

// Module: selfcal_tx
// PURPOSE
//  MBTRAIN self-calibration initiator (TX end). On enable it runs a local calibration wait,
//  sends the SELFCAL end request (4'b0001) over the sideband mux, and waits for the partner's
//  end response (4'b0010). It then raises o_test_ack. A watchdog flags a missing response.
//  The RX responder shares the same sideband mux; the two arbitrate through i_valid_rx/o_valid_tx.
// PARAMETERS
//  CAL_CYCLES      32     clk cycles spent in LOCAL_CAL before the end request (>=1)
//  TIMEOUT_CYCLES  8000   watchdog limit, counted from leaving IDLE (> CAL_CYCLES+4)
//  CNT_W           16     width of both counters (must hold TIMEOUT_CYCLES-1)
// PORTS
//  clk                         in   1  clock
//  rst_n                       in   1  reset, asynchronous, active-low
//  i_en                        in   1  LTSM enable for this substate; low = abort/return to IDLE
//  i_decoded_sideband_message  in   4  decoded received msg; 4'b0010 = end response
//  i_busy_negedge_detected     in   1  sideband TX finished sending current message (1-cycle pulse)
//  i_valid_rx                  in   1  RX responder currently owns the sideband mux
//  o_sideband_message          out  4  message code to encoder; 4'b0001 = end request
//  o_valid_tx                  out  1  request to sideband TX: send o_sideband_message
//  o_test_ack                  out  1  selfcal complete (response received)
//  o_timeout                   out  1  watchdog expired without a response
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pending, cal_cnt, wd_cnt = 0.
//  States: IDLE, LOCAL_CAL, SEND_END_REQ, WAIT_END_RESP, TEST_FINISHED, TIMEOUT_ERR.
//  - IDLE: i_en=1 -> LOCAL_CAL. cal_cnt and wd_cnt are cleared. Outputs are registered to 0.
//  - LOCAL_CAL: cal_cnt increments each cycle. At cal_cnt==CAL_CYCLES-1 -> SEND_END_REQ.
//    On that transition, register o_sideband_message=4'b0001 and set pending=1.
//  - SEND_END_REQ: o_valid_tx reg sets next cycle if pending && !i_valid_rx; held off while i_valid_rx=1.
//    i_busy_negedge_detected while o_valid_tx=1 -> o_valid_tx=0 and pending=0.
//    Falling edge of o_valid_tx (o_valid_tx=0 and its 1-cycle-delayed copy=1) -> WAIT_END_RESP.
//    On that transition, o_sideband_message=0.
//  - WAIT_END_RESP: i_decoded_sideband_message==4'b0010 -> TEST_FINISHED, o_test_ack=1 next cycle.
//    Any other code is ignored. 4'b0010 arriving in any other state is ignored.
//  - TEST_FINISHED: hold o_test_ack=1 until i_en=0 -> IDLE.
//  - TIMEOUT_ERR: o_timeout=1, o_valid_tx=0, pending=0, message=0. Hold until i_en=0 -> IDLE.
//  Watchdog: wd_cnt increments each cycle in LOCAL_CAL/SEND_END_REQ/WAIT_END_RESP.
//    At wd_cnt==TIMEOUT_CYCLES-1 in those states -> TIMEOUT_ERR.
//    If the response and the watchdog limit occur in the same cycle, the response wins (TEST_FINISHED).
//  Abort: i_en=0 in any non-IDLE state -> IDLE next cycle. o_valid_tx, pending, message, ack
//    and timeout clear on that same edge. An in-flight busy negedge afterwards is ignored.
//  i_busy_negedge_detected with o_valid_tx=0 is ignored. o_valid_tx never re-asserts for the
//    same request once pending=0. Exactly one end request is sent per enable.
//  Latency: i_en rise -> o_valid_tx=1 after CAL_CYCLES+2 cycles (i_valid_rx=0).
//    Response sampled -> o_test_ack=1 on the next edge.
//  Async reset mid-operation returns to the reset state immediately. No message is replayed.
// TESTING
//  1 CAL_CYCLES=4, i_en=1, i_valid_rx=0 -> o_valid_tx=1 at cycle 6 with msg 4'b0001.
//    Then busy pulse -> valid 0, msg 0. Then decoded 4'b0010 -> o_test_ack=1 next cycle.
//    Then i_en=0 -> all outputs 0.
//  2 i_valid_rx=1 for 10 cycles over SEND_END_REQ -> o_valid_tx stays 0.
//    It rises 1 cycle after i_valid_rx falls, and the flow completes as in 1.
//  3 Decoded 4'b0010 injected during LOCAL_CAL, and 4'b0001 during WAIT -> ignored.
//    No ack until a genuine 4'b0010 arrives in WAIT_END_RESP.
//  4 TIMEOUT_CYCLES=50, no response -> o_timeout=1 at wd_cnt 49, o_test_ack=0.
//    o_timeout clears after i_en=0. Response and limit in the same cycle -> ack=1, timeout=0.
//  5 i_en dropped while o_valid_tx=1 -> valid/msg 0 next edge, state IDLE.
//    A later busy pulse has no effect, and re-enable restarts cleanly from LOCAL_CAL.
//  6 rst_n asserted in WAIT_END_RESP -> all outputs 0 asynchronously.
//    After release, no request is sent until i_en is sampled high.

Source files
------------

// File: rtl/selfcal_tx.sv
//============================================================================
// Module      : selfcal_tx
// Description : MBTRAIN self-calibration initiator (TX end). When enabled it
//               runs a local calibration wait, then sends one SELFCAL end
//               request (4'b0001) over the shared sideband mux. It then
//               waits for the partner's end response (4'b0010) and raises
//               o_test_ack. A watchdog flags a missing response with
//               o_timeout.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   CAL_CYCLES      clk cycles spent in local calibration (>= 1)
//   TIMEOUT_CYCLES  watchdog limit counted from leaving IDLE (> CAL_CYCLES+4)
//   CNT_W           width of both counters (must hold TIMEOUT_CYCLES-1)
// Ports
//   clk                         in   1  clock
//   rst_n                       in   1  asynchronous active-low reset
//   i_en                        in   1  substate enable; low aborts to IDLE
//   i_decoded_sideband_message  in   4  decoded received message
//   i_busy_negedge_detected     in   1  sideband TX finished current message
//   i_valid_rx                  in   1  RX responder owns the sideband mux
//   o_sideband_message          out  4  message code for the encoder
//   o_valid_tx                  out  1  send request to sideband TX
//   o_test_ack                  out  1  selfcal complete
//   o_timeout                   out  1  watchdog expired without a response
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module selfcal_tx #(
    parameter int CAL_CYCLES     = 32,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_timeout
);

    localparam logic [3:0]       C_MSG_NONE     = 4'b0000;
    localparam logic [3:0]       C_MSG_END_REQ  = 4'b0001;
    localparam logic [3:0]       C_MSG_END_RESP = 4'b0010;
    localparam logic [CNT_W-1:0] C_CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CAL_LAST     = CNT_W'(CAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_WD_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_LOCAL_CAL     = 3'd1,
        ST_SEND_END_REQ  = 3'd2,
        ST_WAIT_END_RESP = 3'd3,
        ST_TEST_FINISHED = 3'd4,
        ST_TIMEOUT_ERR   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cal_cnt_q, cal_cnt_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             pending_q, pending_d;
    logic             valid_tx_q, valid_tx_d;
    logic             valid_tx_dly_q, valid_tx_dly_d;
    logic [3:0]       msg_q, msg_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;

    logic             w_resp_seen;
    logic             w_watch_state;
    logic             w_wd_expired;

    assign w_resp_seen   = (i_decoded_sideband_message == C_MSG_END_RESP);
    assign w_watch_state = (state_q == ST_LOCAL_CAL)    ||
                           (state_q == ST_SEND_END_REQ) ||
                           (state_q == ST_WAIT_END_RESP);
    assign w_wd_expired  = w_watch_state && (wd_cnt_q == C_WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cal_cnt_q      <= C_CNT_ZERO;
            wd_cnt_q       <= C_CNT_ZERO;
            pending_q      <= 1'b0;
            valid_tx_q     <= 1'b0;
            valid_tx_dly_q <= 1'b0;
            msg_q          <= C_MSG_NONE;
            ack_q          <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cal_cnt_q      <= cal_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            pending_q      <= pending_d;
            valid_tx_q     <= valid_tx_d;
            valid_tx_dly_q <= valid_tx_dly_d;
            msg_q          <= msg_d;
            ack_q          <= ack_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cal_cnt_d      = cal_cnt_q;
        wd_cnt_d       = wd_cnt_q;
        pending_d      = pending_q;
        valid_tx_d     = valid_tx_q;
        valid_tx_dly_d = valid_tx_q;
        msg_d          = msg_q;
        ack_d          = ack_q;
        timeout_d      = timeout_q;

        case (state_q)
            ST_IDLE: begin
                cal_cnt_d  = C_CNT_ZERO;
                wd_cnt_d   = C_CNT_ZERO;
                pending_d  = 1'b0;
                valid_tx_d = 1'b0;
                msg_d      = C_MSG_NONE;
                ack_d      = 1'b0;
                timeout_d  = 1'b0;
                if (i_en) begin
                    state_d = ST_LOCAL_CAL;
                end
            end

            ST_LOCAL_CAL: begin
                cal_cnt_d = cal_cnt_q + C_CNT_ONE;
                wd_cnt_d  = wd_cnt_q + C_CNT_ONE;
                if (cal_cnt_q == C_CAL_LAST) begin
                    state_d   = ST_SEND_END_REQ;
                    msg_d     = C_MSG_END_REQ;
                    pending_d = 1'b1;
                end
            end

            ST_SEND_END_REQ: begin
                wd_cnt_d = wd_cnt_q + C_CNT_ONE;
                // Request the mux only while the RX responder is not using it.
                // Gating on pending guarantees a single send per enable.
                if (pending_q && !valid_tx_q && !i_valid_rx) begin
                    valid_tx_d = 1'b1;
                end
                if (valid_tx_q && i_busy_negedge_detected) begin
                    valid_tx_d = 1'b0;
                    pending_d  = 1'b0;
                end
                // The falling edge of our own request marks the message as gone.
                if (!valid_tx_q && valid_tx_dly_q) begin
                    state_d = ST_WAIT_END_RESP;
                    msg_d   = C_MSG_NONE;
                end
            end

            ST_WAIT_END_RESP: begin
                wd_cnt_d = wd_cnt_q + C_CNT_ONE;
                if (w_resp_seen) begin
                    state_d = ST_TEST_FINISHED;
                    ack_d   = 1'b1;
                end
            end

            ST_TEST_FINISHED: begin
                ack_d = 1'b1;
            end

            ST_TIMEOUT_ERR: begin
                timeout_d  = 1'b1;
                valid_tx_d = 1'b0;
                pending_d  = 1'b0;
                msg_d      = C_MSG_NONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response landing on the watchdog limit still counts as success.
        if (w_wd_expired && (state_d != ST_TEST_FINISHED)) begin
            state_d    = ST_TIMEOUT_ERR;
            timeout_d  = 1'b1;
            valid_tx_d = 1'b0;
            pending_d  = 1'b0;
            msg_d      = C_MSG_NONE;
            ack_d      = 1'b0;
        end

        // Losing the enable abandons everything, including a request in flight.
        if ((state_q != ST_IDLE) && !i_en) begin
            state_d    = ST_IDLE;
            cal_cnt_d  = C_CNT_ZERO;
            wd_cnt_d   = C_CNT_ZERO;
            pending_d  = 1'b0;
            valid_tx_d = 1'b0;
            msg_d      = C_MSG_NONE;
            ack_d      = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid_tx         = valid_tx_q;
    assign o_test_ack         = ack_q;
    assign o_timeout          = timeout_q;

endmodule

`default_nettype wire
